// File: rtl/depp_regfile.sv
// depp_regfile: Digilent EPP slave exposing NUM_REGS 8-bit registers to the host
// and to fabric logic. The data-bus tristate lives at the top level; this block
// only provides o_depp_data / o_depp_data_oe.
// Optional feature macro: DEPP_AUTOINC_EN. When it is defined, every accepted
// data-strobe cycle post-increments the address register.
module depp_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_depp_astb_n,
  input  logic                  i_depp_dstb_n,
  input  logic                  i_depp_write_n,
  input  logic [7:0]            i_depp_data,
  output logic [7:0]            o_depp_data,
  output logic                  o_depp_data_oe,
  output logic                  o_depp_wait,
  output logic [NUM_REGS*8-1:0] o_regs,
  input  logic                  i_usr_we,
  input  logic [ADDR_W-1:0]     i_usr_addr,
  input  logic [7:0]            i_usr_wdata,
  output logic                  o_wr_stb,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic                  o_timeout
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0]  NREGS  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE, S_RELEASE} state_t;

  state_t                          r_state;
  logic [SYNC_STAGES-1:0]          r_astb_sync;
  logic [SYNC_STAGES-1:0]          r_dstb_sync;
  logic [SYNC_STAGES-1:0]          r_wrn_sync;
  logic [SYNC_STAGES-1:0][7:0]     r_data_sync;
  logic [ADDR_W-1:0]               r_addr;
  logic [CNT_W-1:0]                r_cnt;
  logic [7:0]                      r_regs [NUM_REGS];

  logic                            w_astb;
  logic                            w_dstb;
  logic                            w_wrn;
  logic [7:0]                      w_data;
  logic                            w_host_in_rng;
  logic                            w_usr_in_rng;
  logic [IDX_W-1:0]                w_host_idx;
  logic [IDX_W-1:0]                w_usr_idx;

  assign w_astb        = r_astb_sync[SYNC_STAGES-1];
  assign w_dstb        = r_dstb_sync[SYNC_STAGES-1];
  assign w_wrn         = r_wrn_sync[SYNC_STAGES-1];
  assign w_data        = r_data_sync[SYNC_STAGES-1];
  assign w_host_in_rng = ({1'b0, r_addr} < NREGS);
  assign w_usr_in_rng  = ({1'b0, i_usr_addr} < NREGS);
  assign w_host_idx    = r_addr[IDX_W-1:0];
  assign w_usr_idx     = i_usr_addr[IDX_W-1:0];

  // Flatten the register array onto the fabric-facing bus.
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign o_regs[8*g +: 8] = r_regs[g];
    end
  endgenerate

  // Synchronisers. Strobes reset to the asserted level so that a strobe already
  // low when reset ends never looks like a fresh falling edge to the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_astb_sync <= '0;
      r_dstb_sync <= '0;
      r_wrn_sync  <= '1;
      r_data_sync <= '0;
    end else begin
      r_astb_sync <= {r_astb_sync[SYNC_STAGES-2:0], i_depp_astb_n};
      r_dstb_sync <= {r_dstb_sync[SYNC_STAGES-2:0], i_depp_dstb_n};
      r_wrn_sync  <= {r_wrn_sync[SYNC_STAGES-2:0], i_depp_write_n};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_depp_data};
    end
  end

  // Handshake FSM plus register file; the host write is placed after the fabric
  // write so it overrides a same-edge fabric write to the same register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_RELEASE;
      r_addr         <= '0;
      r_cnt          <= '0;
      o_depp_data    <= '0;
      o_depp_data_oe <= 1'b0;
      o_depp_wait    <= 1'b0;
      o_wr_stb       <= 1'b0;
      o_wr_addr      <= '0;
      o_timeout      <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      o_wr_stb  <= 1'b0;
      o_timeout <= 1'b0;

      if (i_usr_we && w_usr_in_rng) r_regs[w_usr_idx] <= i_usr_wdata;

      case (r_state)
        S_IDLE: begin
          if (!w_astb) begin
            if (!w_wrn) begin
              r_addr <= w_data[ADDR_W-1:0];
            end else begin
              o_depp_data    <= 8'(r_addr);
              o_depp_data_oe <= 1'b1;
            end
            o_depp_wait <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_RELEASE;
          end else if (!w_dstb) begin
            if (!w_wrn) begin
              if (w_host_in_rng) begin
                r_regs[w_host_idx] <= w_data;
                o_wr_stb           <= 1'b1;
                o_wr_addr          <= r_addr;
              end
            end else begin
              o_depp_data    <= w_host_in_rng ? r_regs[w_host_idx] : 8'h00;
              o_depp_data_oe <= 1'b1;
            end
`ifdef DEPP_AUTOINC_EN
            r_addr <= r_addr + 1'b1;
`endif
            o_depp_wait <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_astb && w_dstb) begin
            o_depp_wait    <= 1'b0;
            o_depp_data_oe <= 1'b0;
            r_cnt          <= '0;
            r_state        <= S_IDLE;
          end else if (r_cnt != TO_MAX) begin
            // Saturating count; the forced release happens exactly once.
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == TO_PRE) begin
              o_depp_wait    <= 1'b0;
              o_depp_data_oe <= 1'b0;
              o_timeout      <= 1'b1;
            end
          end
        end
        default: r_state <= S_RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_depp_regfile.sv
// Directed bench for depp_regfile (default parameters). Drives the DEPP pins
// one cycle-phase after the rising edge and samples 1 ns after the edge.
module tb_depp_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic         astb_n, dstb_n, write_n;
  logic [7:0]   din;
  logic [7:0]   dout;
  logic         oe, dwait;
  logic [127:0] regs;
  logic         usr_we;
  logic [7:0]   usr_addr, usr_wdata;
  logic         wr_stb;
  logic [7:0]   wr_addr;
  logic         tmo;

  int assertions = 0;
  int failures   = 0;
  int stb_cnt    = 0;
  int to_cnt     = 0;
  logic [7:0]   last_waddr = 8'h00;
  logic [127:0] exp_regs   = '0;

  always #5 clk = ~clk;

  depp_regfile dut (
    .i_clk(clk), .i_rst(rst),
    .i_depp_astb_n(astb_n), .i_depp_dstb_n(dstb_n), .i_depp_write_n(write_n),
    .i_depp_data(din), .o_depp_data(dout), .o_depp_data_oe(oe), .o_depp_wait(dwait),
    .o_regs(regs), .i_usr_we(usr_we), .i_usr_addr(usr_addr), .i_usr_wdata(usr_wdata),
    .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_timeout(tmo)
  );

  // Pulse monitors for write strobes and timeouts.
  always @(posedge clk) begin
    #1;
    if (wr_stb) begin stb_cnt++; last_waddr = wr_addr; end
    if (tmo) to_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Bounded wait for o_depp_wait to reach lvl.
  task automatic wait_for_wait(input logic lvl, input string tag);
    int n = 0;
    while (dwait !== lvl && n < 30) begin tick(1); n++; end
    assertions++;
    if (dwait !== lvl) begin
      failures++;
      $display("FAIL %s: wait=%b expected %b", tag, dwait, lvl);
    end
  endtask

  task automatic host_cycle(input bit is_addr, input bit wr, input logic [7:0] d,
                            output logic [7:0] rd, output logic oe_s);
    write_n = ~wr; din = d;
    if (is_addr) astb_n = 1'b0; else dstb_n = 1'b0;
    wait_for_wait(1'b1, "hs_rise");
    rd = dout; oe_s = oe;
    astb_n = 1'b1; dstb_n = 1'b1;
    wait_for_wait(1'b0, "hs_fall");
    write_n = 1'b1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    logic [7:0] rd; logic o;
    host_cycle(1'b1, 1'b1, a, rd, o);
  endtask

  task automatic test_reset;
    logic [7:0] rd; logic o;
    rst = 1'b1; astb_n = 1'b1; dstb_n = 1'b1; write_n = 1'b1; din = 8'h00;
    usr_we = 1'b0; usr_addr = 8'h00; usr_wdata = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(1);
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL rst_wait: got %b want 0", dwait); end
    assertions++; if (oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b want 0", oe); end
    assertions++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL rst_wr_stb: got %b want 0", wr_stb); end
    assertions++; if (tmo !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b want 0", tmo); end
    assertions++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_dout: got %h want 00", dout); end
    assertions++; if (regs !== 128'h0) begin failures++; $display("FAIL rst_regs: got %h want 0", regs); end
    assertions++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL rst_wr_addr: got %h want 00", wr_addr); end
    tick(4);
    host_cycle(1'b1, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'h00) begin failures++; $display("FAIL rst_addr_reg: got %h want 00", rd); end
  endtask

  task automatic test_addr;
    logic [7:0] rd; logic o;
    write_n = 1'b0; din = 8'h05; astb_n = 1'b0;
    tick(2);
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL lat_rise_early: got %b want 0", dwait); end
    tick(1);
    assertions++; if (dwait !== 1'b1) begin failures++; $display("FAIL lat_rise: got %b want 1", dwait); end
    astb_n = 1'b1;
    tick(2);
    assertions++; if (dwait !== 1'b1) begin failures++; $display("FAIL lat_fall_early: got %b want 1", dwait); end
    tick(1);
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL lat_fall: got %b want 0", dwait); end
    write_n = 1'b1;
    host_cycle(1'b1, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'h05) begin failures++; $display("FAIL addr_read: got %h want 05", rd); end
    assertions++; if (o !== 1'b1) begin failures++; $display("FAIL addr_read_oe: got %b want 1", o); end
    assertions++; if (oe !== 1'b0 || dwait !== 1'b0) begin failures++; $display("FAIL addr_release: oe=%b wait=%b want 0/0", oe, dwait); end
  endtask

  task automatic test_data;
    logic [7:0] rd; logic o; int s0;
    set_addr(8'h03);
    s0 = stb_cnt;
    host_cycle(1'b0, 1'b1, 8'hA5, rd, o);
    exp_regs[31:24] = 8'hA5;
    assertions++; if (regs !== exp_regs) begin failures++; $display("FAIL data_write: got %h want %h", regs, exp_regs); end
    assertions++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL data_wr_stb: got %0d pulses want 1", stb_cnt - s0); end
    assertions++; if (last_waddr !== 8'h03) begin failures++; $display("FAIL data_wr_addr: got %h want 03", last_waddr); end
    host_cycle(1'b1, 1'b0, 8'h00, rd, o);
`ifdef DEPP_AUTOINC_EN
    assertions++; if (rd !== 8'h04) begin failures++; $display("FAIL addr_after_write: got %h want 04", rd); end
`else
    assertions++; if (rd !== 8'h03) begin failures++; $display("FAIL addr_after_write: got %h want 03", rd); end
`endif
    set_addr(8'h03);
    host_cycle(1'b0, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'hA5 || o !== 1'b1) begin failures++; $display("FAIL data_read: got %h oe=%b want a5 oe=1", rd, o); end
  endtask

  task automatic test_oob;
    logic [7:0] rd; logic o; int s0;
    set_addr(8'hF0);
    s0 = stb_cnt;
    host_cycle(1'b0, 1'b1, 8'h11, rd, o);
    assertions++; if (regs !== exp_regs) begin failures++; $display("FAIL oob_write: got %h want %h", regs, exp_regs); end
    assertions++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL oob_wr_stb: got %0d pulses want 0", stb_cnt - s0); end
    set_addr(8'hF0);
    host_cycle(1'b0, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'h00 || o !== 1'b1) begin failures++; $display("FAIL oob_read: got %h oe=%b want 00 oe=1", rd, o); end
  endtask

  task automatic test_collision;
    set_addr(8'h02);
    write_n = 1'b0; din = 8'h3C; dstb_n = 1'b0;
    tick(2);
    usr_we = 1'b1; usr_addr = 8'h02; usr_wdata = 8'hC3;
    tick(1);
    usr_we = 1'b0;
    assertions++; if (dwait !== 1'b1) begin failures++; $display("FAIL coll_wait: got %b want 1", dwait); end
    dstb_n = 1'b1;
    wait_for_wait(1'b0, "coll_release");
    write_n = 1'b1;
    exp_regs[23:16] = 8'h3C;
    assertions++; if (regs[23:16] !== 8'h3C) begin failures++; $display("FAIL coll_host_wins: got %h want 3c", regs[23:16]); end
    usr_we = 1'b1; usr_addr = 8'h04; usr_wdata = 8'h77;
    assertions++; if (regs[39:32] !== 8'h00) begin failures++; $display("FAIL usr_before_edge: got %h want 00", regs[39:32]); end
    tick(1);
    usr_we = 1'b0;
    exp_regs[39:32] = 8'h77;
    assertions++; if (regs[39:32] !== 8'h77) begin failures++; $display("FAIL usr_write: got %h want 77", regs[39:32]); end
    usr_we = 1'b1; usr_addr = 8'h20; usr_wdata = 8'hFF;
    tick(1);
    usr_we = 1'b0;
    assertions++; if (regs !== exp_regs) begin failures++; $display("FAIL usr_oob: got %h want %h", regs, exp_regs); end
    // Fabric overwrites the register while the host read is parked in RELEASE.
    set_addr(8'h03);
    write_n = 1'b1; dstb_n = 1'b0;
    wait_for_wait(1'b1, "rdhold_rise");
    usr_we = 1'b1; usr_addr = 8'h03; usr_wdata = 8'h5A;
    tick(1);
    usr_we = 1'b0;
    tick(2);
    exp_regs[31:24] = 8'h5A;
    assertions++; if (dout !== 8'hA5) begin failures++; $display("FAIL rdhold_dout: got %h want a5", dout); end
    assertions++; if (regs[31:24] !== 8'h5A) begin failures++; $display("FAIL rdhold_reg: got %h want 5a", regs[31:24]); end
    dstb_n = 1'b1;
    wait_for_wait(1'b0, "rdhold_fall");
  endtask

  task automatic test_timeout;
    logic [7:0] rd; logic o; int n; int s_to;
    set_addr(8'h01);
    write_n = 1'b1; dstb_n = 1'b0;
    wait_for_wait(1'b1, "to_rise");
    s_to = to_cnt;
    n = 0;
    while (dwait === 1'b1 && n < 400) begin tick(1); n++; end
    assertions++; if (n !== 255) begin failures++; $display("FAIL to_cycles: got %0d want 255", n); end
    assertions++; if (tmo !== 1'b1) begin failures++; $display("FAIL to_pulse: got %b want 1", tmo); end
    assertions++; if (oe !== 1'b0) begin failures++; $display("FAIL to_oe: got %b want 0", oe); end
    tick(45);
    assertions++; if (to_cnt - s_to !== 1) begin failures++; $display("FAIL to_once: got %0d pulses want 1", to_cnt - s_to); end
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL to_held: got %b want 0", dwait); end
    dstb_n = 1'b1;
    tick(6);
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL to_no_retrigger: got %b want 0", dwait); end
    set_addr(8'h04);
    host_cycle(1'b0, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'h77) begin failures++; $display("FAIL to_recover: got %h want 77", rd); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; logic o;
    set_addr(8'h03);
    write_n = 1'b1; dstb_n = 1'b0;
    wait_for_wait(1'b1, "rstmid_rise");
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    exp_regs = '0;
    assertions++; if (dwait !== 1'b0 || oe !== 1'b0) begin failures++; $display("FAIL rstmid_hs: wait=%b oe=%b want 0/0", dwait, oe); end
    assertions++; if (regs !== exp_regs) begin failures++; $display("FAIL rstmid_regs: got %h want 0", regs); end
    tick(10);
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL rstmid_ignore: got %b want 0", dwait); end
    dstb_n = 1'b1;
    tick(6);
    assertions++; if (dwait !== 1'b0) begin failures++; $display("FAIL rstmid_after_rise: got %b want 0", dwait); end
    host_cycle(1'b1, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'h00) begin failures++; $display("FAIL rstmid_addr: got %h want 00", rd); end
  endtask

`ifdef DEPP_AUTOINC_EN
  task automatic test_autoinc;
    logic [7:0] rd; logic o; int s0;
    set_addr(8'hFE);
    s0 = stb_cnt;
    host_cycle(1'b0, 1'b1, 8'h11, rd, o);
    host_cycle(1'b0, 1'b1, 8'h22, rd, o);
    host_cycle(1'b0, 1'b1, 8'h33, rd, o);
    host_cycle(1'b0, 1'b1, 8'h44, rd, o);
    exp_regs[7:0] = 8'h33; exp_regs[15:8] = 8'h44;
    assertions++; if (regs !== exp_regs) begin failures++; $display("FAIL ai_regs: got %h want %h", regs, exp_regs); end
    assertions++; if (stb_cnt - s0 !== 2) begin failures++; $display("FAIL ai_stb: got %0d want 2", stb_cnt - s0); end
    assertions++; if (last_waddr !== 8'h01) begin failures++; $display("FAIL ai_wr_addr: got %h want 01", last_waddr); end
    host_cycle(1'b1, 1'b0, 8'h00, rd, o);
    assertions++; if (rd !== 8'h02) begin failures++; $display("FAIL ai_addr: got %h want 02", rd); end
  endtask
`endif

  initial begin
    test_reset;
    test_addr;
    test_data;
    test_oob;
    test_collision;
    test_timeout;
    test_reset_mid;
`ifdef DEPP_AUTOINC_EN
    test_autoinc;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
